// File: rtl/scan_pkg.sv
// Shared encodings for the console token scanner: scan modes, FSM states and ASCII codes.
package scan_pkg;

    typedef enum logic [1:0] {
        MODE_CHAR = 2'd0,
        MODE_HEXF = 2'd1,
        MODE_HEXV = 2'd2,
        MODE_DEC  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;

endpackage

// File: rtl/scan_token_if.sv
// Byte stream in / token result out between the UART RX path and the command FSM.
interface scan_token_if #(
    parameter int unsigned DATA_W = 32
);
    logic [7:0]        d_rx;
    logic              vld_rx;
    logic              rdy_rx;
    logic              req_rx;
    logic [1:0]        type_rx;
    logic              ack_rx;
    logic [DATA_W-1:0] din_rx;
    logic [7:0]        ndig_rx;
    logic              err_rx;
    logic              eol_rx;
    logic              tmo_rx;

    modport master (
        output d_rx, vld_rx, req_rx, type_rx,
        input  rdy_rx, ack_rx, din_rx, ndig_rx, err_rx, eol_rx, tmo_rx
    );

    modport slave (
        input  d_rx, vld_rx, req_rx, type_rx,
        output rdy_rx, ack_rx, din_rx, ndig_rx, err_rx, eol_rx, tmo_rx
    );
endinterface

// File: rtl/ascii_class.sv
// Combinational character classifier: digit classes, whitespace, line end, backspace and nibble value.
module ascii_class
    import scan_pkg::*;
(
    input  logic [7:0] i_d,
    output logic       o_is_hex_c,
    output logic       o_is_dec_c,
    output logic       o_is_ws_c,
    output logic       o_is_eol_c,
    output logic       o_is_bs_c,
    output logic [3:0] o_nib_c
);

    logic w_upper;
    logic w_lower;

    always_comb begin
        o_is_dec_c = (i_d >= 8'h30) && (i_d <= 8'h39);
        w_upper    = (i_d >= 8'h41) && (i_d <= 8'h46);
        w_lower    = (i_d >= 8'h61) && (i_d <= 8'h66);
        o_is_hex_c = o_is_dec_c || w_upper || w_lower;
        o_is_ws_c  = (i_d == CH_SP) || (i_d == CH_TAB);
        o_is_eol_c = (i_d == CH_CR) || (i_d == CH_LF);
        o_is_bs_c  = (i_d == CH_BS) || (i_d == CH_DEL);
        // Letters A-F / a-f both carry 1..6 in the low nibble
        o_nib_c    = o_is_dec_c ? i_d[3:0] : (i_d[3:0] + 4'd9);
    end

endmodule

// File: rtl/scan_token.sv
// Console token scanner: skips leading whitespace, collects one CHAR/HEX/DEC token with
// backspace editing, and reports value, digit count, error, end-of-line and timeout.
module scan_token
    import scan_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TMO_W   = 24,
    parameter int unsigned TMO_CYC = 0
) (
    input  logic        clk,
    input  logic        rst,
    scan_token_if.slave scan_if
);

    localparam int unsigned MAX_DIG = DATA_W / 4;
    localparam int unsigned PROD_W  = DATA_W + 4;
    localparam logic [TMO_W-1:0] TMO_LAST = (TMO_CYC == 0) ? '0 : TMO_W'(TMO_CYC - 1);

    state_e            r_state,  w_next_state;
    mode_e             r_mode,   w_mode;
    logic [DATA_W-1:0] r_din,    w_din;
    logic [7:0]        r_ndig,   w_ndig;
    logic              r_err,    w_err;
    logic              r_eol,    w_eol;
    logic              r_tmo,    w_tmo;
    logic [TMO_W-1:0]  r_cnt,    w_cnt;
    logic              r_rdy,    w_rdy_nx;
    logic              r_ack,    w_ack_nx;

    logic              w_is_hex, w_is_dec, w_is_ws, w_is_eol, w_is_bs;
    logic [3:0]        w_nib;
    logic              w_acc, w_in_skip, w_is_cr, w_is_digit, w_full, w_last, w_ovf;
    logic [PROD_W-1:0] w_prod;

    ascii_class u_class (
        .i_d        (scan_if.d_rx),
        .o_is_hex_c (w_is_hex),
        .o_is_dec_c (w_is_dec),
        .o_is_ws_c  (w_is_ws),
        .o_is_eol_c (w_is_eol),
        .o_is_bs_c  (w_is_bs),
        .o_nib_c    (w_nib)
    );

    // Datapath helpers: decimal accumulate with overflow detect, digit limits
    always_comb begin
        w_acc      = scan_if.vld_rx & r_rdy;
        w_in_skip  = (r_state == ST_SKIP);
        w_is_cr    = (scan_if.d_rx == CH_CR);
        w_is_digit = (r_mode == MODE_DEC) ? w_is_dec : w_is_hex;
        w_full     = (r_ndig == 8'(MAX_DIG));
        w_last     = ((r_ndig + 8'd1) == 8'(MAX_DIG));
        w_prod     = PROD_W'(r_din) * PROD_W'(10) + PROD_W'(w_nib);
        w_ovf      = |w_prod[PROD_W-1:DATA_W];
    end

    always_comb begin
        w_next_state = r_state;
        w_mode       = r_mode;
        w_din        = r_din;
        w_ndig       = r_ndig;
        w_err        = r_err;
        w_eol        = r_eol;
        w_tmo        = r_tmo;
        w_cnt        = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (scan_if.req_rx) begin
                    w_mode       = mode_e'(scan_if.type_rx);
                    w_din        = '0;
                    w_ndig       = '0;
                    w_err        = 1'b0;
                    w_eol        = 1'b0;
                    w_tmo        = 1'b0;
                    w_cnt        = '0;
                    w_next_state = ST_SKIP;
                end
            end

            ST_SKIP, ST_COLLECT: begin
                if (w_acc) begin
                    w_cnt = '0;
                    if (w_in_skip && (w_is_ws || (w_is_eol && !w_is_cr))) begin
                        w_next_state = ST_SKIP;
                    end else if (w_in_skip && w_is_cr) begin
                        w_ndig       = '0;
                        w_err        = 1'b1;
                        w_eol        = 1'b1;
                        w_next_state = ST_DONE;
                    end else if (w_in_skip && w_is_bs) begin
                        w_next_state = ST_SKIP;
                    end else if (r_mode == MODE_CHAR) begin
                        w_din        = DATA_W'(scan_if.d_rx);
                        w_ndig       = 8'd1;
                        w_next_state = ST_DONE;
                    end else if (w_is_digit) begin
                        w_next_state = ST_COLLECT;
                        if (r_mode == MODE_DEC) begin
                            if (w_ovf) begin
                                w_err = 1'b1;
                            end else begin
                                w_din  = w_prod[DATA_W-1:0];
                                w_ndig = r_ndig + 8'd1;
                            end
                        end else if ((r_mode == MODE_HEXV) && w_full) begin
                            w_err = 1'b1;
                        end else begin
                            w_din  = {r_din[DATA_W-5:0], w_nib};
                            w_ndig = r_ndig + 8'd1;
                            if ((r_mode == MODE_HEXF) && w_last) begin
                                w_next_state = ST_DONE;
                            end
                        end
                    end else if (w_is_ws || w_is_eol) begin
                        w_eol        = w_is_eol;
                        w_next_state = ST_DONE;
                        if ((r_mode == MODE_HEXF) && !w_full) begin
                            w_err = 1'b1;
                        end
                    end else if (w_is_bs) begin
                        // Value never holds more digits than ndig, so erasing the last one clears it
                        if ((r_mode == MODE_DEC) || (r_ndig <= 8'd1)) begin
                            w_din        = '0;
                            w_ndig       = '0;
                            w_next_state = ST_SKIP;
                        end else begin
                            w_din        = r_din >> 4;
                            w_ndig       = r_ndig - 8'd1;
                            w_next_state = ST_COLLECT;
                        end
                    end else begin
                        w_err        = 1'b1;
                        w_next_state = ST_COLLECT;
                    end
                end else if (TMO_CYC != 0) begin
                    if (r_cnt == TMO_LAST) begin
                        w_err        = 1'b1;
                        w_tmo        = 1'b1;
                        w_next_state = ST_DONE;
                    end else begin
                        w_cnt = r_cnt + TMO_W'(1);
                    end
                end
            end

            ST_DONE: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        w_rdy_nx = (w_next_state == ST_SKIP) || (w_next_state == ST_COLLECT);
        w_ack_nx = (w_next_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_CHAR;
            r_din   <= '0;
            r_ndig  <= '0;
            r_err   <= 1'b0;
            r_eol   <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_mode  <= w_mode;
            r_din   <= w_din;
            r_ndig  <= w_ndig;
            r_err   <= w_err;
            r_eol   <= w_eol;
            r_tmo   <= w_tmo;
            r_cnt   <= w_cnt;
            r_rdy   <= w_rdy_nx;
            r_ack   <= w_ack_nx;
        end
    end

    assign scan_if.rdy_rx  = r_rdy;
    assign scan_if.ack_rx  = r_ack;
    assign scan_if.din_rx  = r_din;
    assign scan_if.ndig_rx = r_ndig;
    assign scan_if.err_rx  = r_err;
    assign scan_if.eol_rx  = r_eol;
    assign scan_if.tmo_rx  = r_tmo;

endmodule

// File: tb/tb_scan_token.sv
// Bench for scan_token: directed token strings, a digit-list reference model and a per-cycle checker.
module tb_scan_token;

    localparam int TMO    = 100;
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rst;

    scan_token_if #(.DATA_W(32)) u_if ();

    scan_token #(
        .DATA_W  (32),
        .TMO_W   (24),
        .TMO_CYC (TMO)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .scan_if (u_if)
    );

    always #5 clk = ~clk;

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;
    bit  tok_active = 1'b0;

    logic [31:0] exp_din;
    logic [7:0]  exp_ndig;
    logic        exp_err, exp_eol, exp_tmo;

    byte unsigned tok_q[$];
    logic [31:0]  m_din;
    int           m_ndig, m_cons, m_lat;
    bit           m_err, m_eol, m_tmo;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int digit_val(input byte unsigned c, input bit dec);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (!dec && c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (!dec && c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic longint unsigned value_of(input int q[$], input int base);
        longint unsigned v = 0;
        foreach (q[i]) v = v * 64'(base) + 64'(q[i]);
        return v;
    endfunction

    // Reference: token kept as a list of digit values; editing pushes/pops, value folded at the end
    function automatic void run_model(input int mode, input int gap_at, input int gap);
        int           digs[$];
        bit           coll, done, is_char;
        int           dv;
        byte unsigned c, ch;
        coll = 0; done = 0; is_char = 0; ch = 0;
        m_err = 0; m_eol = 0; m_tmo = 0; m_cons = 0; m_lat = 1;
        for (int i = 0; i < tok_q.size() && !done; i++) begin
            c = tok_q[i];
            m_cons++;
            if (!coll && (c == 8'h20 || c == 8'h09 || c == 8'h0A)) begin
                coll = 0;
            end else if (!coll && c == 8'h0D) begin
                m_err = 1; m_eol = 1; done = 1;
            end else if (!coll && (c == 8'h08 || c == 8'h7F)) begin
                coll = 0;
            end else if (mode == 0) begin
                ch = c; is_char = 1; done = 1;
            end else begin
                coll = 1;
                dv = digit_val(c, mode == 3);
                if (dv >= 0) begin
                    if (mode == 2 && digs.size() == 8) m_err = 1;
                    else if (mode == 3 && value_of(digs, 10) * 10 + 64'(dv) > 64'hFFFF_FFFF) m_err = 1;
                    else begin
                        digs.push_back(dv);
                        if (mode == 1 && digs.size() == 8) done = 1;
                    end
                end else if (c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A) begin
                    done = 1;
                    m_eol = (c == 8'h0D || c == 8'h0A);
                    if (mode == 1 && digs.size() < 8) m_err = 1;
                end else if (c == 8'h08 || c == 8'h7F) begin
                    if (mode == 3) digs.delete();
                    else if (digs.size() > 0) void'(digs.pop_back());
                    if (digs.size() == 0) coll = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (!done && i == gap_at && gap >= TMO) begin
                done = 1; m_err = 1; m_tmo = 1; m_lat = TMO + 1;
            end
        end
        if (!done) begin
            m_err = 1; m_tmo = 1; m_lat = TMO + 1;
        end
        m_din  = is_char ? 32'(ch) : 32'(value_of(digs, (mode == 3) ? 10 : 16));
        m_ndig = is_char ? 1 : digs.size();
    endfunction

    // Per-cycle compare: full result on ack, held outputs with rdy low while idle
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            if (u_if.ack_rx) begin
                chk("result",
                    64'({u_if.din_rx, u_if.ndig_rx, u_if.err_rx, u_if.eol_rx, u_if.tmo_rx, u_if.rdy_rx}),
                    64'({exp_din, exp_ndig, exp_err, exp_eol, exp_tmo, 1'b0}));
            end else if (!tok_active) begin
                chk("idle_hold",
                    64'({u_if.rdy_rx, u_if.ack_rx, u_if.din_rx, u_if.ndig_rx, u_if.err_rx, u_if.eol_rx, u_if.tmo_rx}),
                    64'({2'b00, exp_din, exp_ndig, exp_err, exp_eol, exp_tmo}));
            end
        end
    end

    task automatic run_case(input string nm, input int mode, input string s, input int gap_at, input int gap,
                            input logic [31:0] l_din, input int l_ndig, input bit l_err, input bit l_eol,
                            input bit l_tmo, input int l_cons);
        int idx, cyc, last, gap_left;
        bit seen;
        tok_q.delete();
        for (int i = 0; i < s.len(); i++) tok_q.push_back(s[i]);
        run_model(mode, gap_at, gap);
        chk({nm, "_model"},
            64'({m_din, 8'(m_ndig), m_err, m_eol, m_tmo, 16'(m_cons)}),
            64'({l_din, 8'(l_ndig), l_err, l_eol, l_tmo, 16'(l_cons)}));
        @(negedge clk);
        tok_active = 1;
        exp_din = m_din; exp_ndig = 8'(m_ndig); exp_err = m_err; exp_eol = m_eol; exp_tmo = m_tmo;
        u_if.req_rx  = 1'b1;
        u_if.type_rx = 2'(mode);
        @(negedge clk);
        u_if.req_rx = 1'b0;
        idx = 0; cyc = 0; last = 0; gap_left = 0; seen = 0;
        for (int k = 0; k < BUDGET && !seen; k++) begin
            if (u_if.ack_rx) begin
                seen = 1;
            end else begin
                if (gap_left > 0) begin
                    u_if.vld_rx = 1'b0;
                    gap_left--;
                end else if (idx < tok_q.size()) begin
                    u_if.vld_rx = 1'b1;
                    u_if.d_rx   = tok_q[idx];
                end else begin
                    u_if.vld_rx = 1'b0;
                end
                if (u_if.vld_rx && u_if.rdy_rx) begin
                    last = cyc;
                    if (idx == gap_at) gap_left = gap;
                    idx++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        u_if.vld_rx = 1'b0;
        chk({nm, "_ack_seen"}, 64'(seen), 64'(1));
        chk({nm, "_consumed"}, 64'(idx), 64'(m_cons));
        chk({nm, "_latency"}, 64'(cyc - last), 64'(m_lat));
        tok_active = 0;
    endtask

    initial begin
        rst = 1'b1;
        u_if.d_rx = 8'h00; u_if.vld_rx = 1'b0; u_if.req_rx = 1'b0; u_if.type_rx = 2'd0;
        exp_din = '0; exp_ndig = '0; exp_err = 0; exp_eol = 0; exp_tmo = 0;
        repeat (3) @(negedge clk);
        chk("reset",
            64'({u_if.rdy_rx, u_if.ack_rx, u_if.din_rx, u_if.ndig_rx, u_if.err_rx, u_if.eol_rx, u_if.tmo_rx}),
            64'(0));
        rst = 1'b0;
        chk_en = 1'b1;

        run_case("hexf_full",   1, "  1a2B3c4D5",  -1, 0,   32'h1A2B3C4D, 8, 0, 0, 0, 10);
        run_case("hexv_bs",     2, "7F\010\0103e\r", -1, 0, 32'h0000003E, 2, 0, 1, 0, 7);
        run_case("hexv_lf",     2, "\nA ",         -1, 0,   32'h0000000A, 1, 0, 0, 0, 3);
        run_case("dec_max",     3, "4294967295 ",  -1, 0,   32'hFFFFFFFF, 10, 0, 0, 0, 11);
        run_case("dec_ovf",     3, "4294967296 ",  -1, 0,   32'd429496729, 9, 1, 0, 0, 11);
        run_case("hexv_bad",    2, "12G4 ",        -1, 0,   32'h00000124, 3, 1, 0, 0, 5);
        run_case("char_cr",     0, "\r",           -1, 0,   32'h00000000, 0, 1, 1, 0, 1);
        run_case("char_q",      0, "  q",          -1, 0,   32'h00000071, 1, 0, 0, 0, 3);
        run_case("hexf_short",  1, "12AB\r",       -1, 0,   32'h000012AB, 4, 1, 1, 0, 5);
        run_case("hexv_9dig",   2, "123456789 ",   -1, 0,   32'h12345678, 8, 1, 0, 0, 10);
        run_case("dec_del",     3, "12\1777\r",    -1, 0,   32'h00000007, 1, 0, 1, 0, 5);
        run_case("tmo_idle",    2, "5",             0, 0,   32'h00000005, 1, 1, 0, 1, 1);
        run_case("tmo_edge_ok", 2, "5 ",            0, 99,  32'h00000005, 1, 0, 0, 0, 2);
        run_case("tmo_edge",    2, "5 ",            0, 100, 32'h00000005, 1, 1, 0, 1, 1);
        run_case("bad_then_bs", 2, "Z\0109 ",      -1, 0,   32'h00000009, 1, 1, 0, 0, 4);

        // Reset in the middle of a HEXF token
        @(negedge clk);
        tok_active = 1;
        u_if.type_rx = 2'd1;
        u_if.req_rx  = 1'b1;
        @(negedge clk);
        u_if.req_rx = 1'b0;
        u_if.vld_rx = 1'b1;
        u_if.d_rx   = 8'h41;
        @(negedge clk);
        u_if.d_rx = 8'h42;
        @(negedge clk);
        u_if.vld_rx = 1'b0;
        chk("pre_rst_ndig", 64'(u_if.ndig_rx), 64'(2));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid",
            64'({u_if.rdy_rx, u_if.ack_rx, u_if.din_rx, u_if.ndig_rx, u_if.err_rx, u_if.eol_rx, u_if.tmo_rx}),
            64'(0));
        rst = 1'b0;
        exp_din = '0; exp_ndig = '0; exp_err = 0; exp_eol = 0; exp_tmo = 0;
        tok_active = 0;

        run_case("after_rst",   1, "00000001",     -1, 0,   32'h00000001, 8, 0, 0, 0, 8);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
